stack_unit: RTL and testbench
=============================

STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 Parameter WIDTH, default 8, stack entry and operand width in bits.
REQ-002 Parameter DEPTH, default 16, number of stack entries; power of two.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  1  request one stack operation; sampled only in IDLE.
REQ-006 ALUSrc  input  1  controller operand count: 1 = pop one, 0 = pop two; sampled with req.
REQ-007 RegWrite  input  1  controller result push enable; sampled with req.
REQ-008 push_only  input  1  push wb_data with zero pops; overrides ALUSrc and RegWrite; sampled with req.
REQ-009 wb_data  input  WIDTH  push data; sampled in IDLE for push_only, in EXEC otherwise.
REQ-010 opa  output  WIDTH  popped top-of-stack operand.
REQ-011 opb  output  WIDTH  popped second operand; 0 when one pop.
REQ-012 opnd_valid  output  1  one-cycle strobe: opa/opb valid, result expected on wb_data.
REQ-013 ack  output  1  one-cycle operation-complete strobe.
REQ-014 err  output  1  high with ack when the operation was rejected.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 sp  output  log2(DEPTH)+1  entry count, 0..DEPTH.
REQ-017 empty / full  output  1 each  sp==0 / sp==DEPTH.

Function
REQ-018 States SHALL be IDLE, RD_A, RD_B, EXEC, WRITE, DONE, ERR; storage SHALL be single-read-port, one access per cycle.
REQ-019 IDLE, req=1, push_only=1: sp==DEPTH -> ERR; else latch wb_data -> WRITE.
REQ-020 IDLE, req=1, push_only=0: need = ALUSrc?1:2; sp<need -> ERR; else -> RD_A.
REQ-021 RD_A: opa <= mem[sp-1]; opb <= 0 if need==1; -> RD_B if need==2, else EXEC.
REQ-022 RD_B: opb <= mem[sp-2]; -> EXEC.
REQ-023 EXEC: opnd_valid=1; sp <= sp-need; latch wb_data; -> WRITE if RegWrite, else DONE.
REQ-024 WRITE: mem[sp] <= latched data; sp <= sp+1; -> DONE.
REQ-025 DONE: ack=1 for one cycle; -> IDLE.
REQ-026 ERR: ack=1, err=1 for one cycle; sp and storage unchanged; -> IDLE.
REQ-027 req outside IDLE SHALL be ignored; control inputs are sampled only in the req cycle.
REQ-028 Latency from the req cycle (c0) to ack: two-pop+push c5, one-pop+push c4, one-pop no-push c3, push_only c2, rejected c1.
REQ-029 opa/opb SHALL hold their values until the next RD_A or RD_B.
REQ-030 Pop-then-push SHALL never overflow; overflow is possible only via push_only.

Reset
REQ-031 Reset SHALL force IDLE, sp=0, opa=opb=0, opnd_valid=ack=err=busy=0, empty=1, full=0, at any time, including mid-operation.
REQ-032 Storage contents SHALL NOT be reset.

Verification
REQ-033 Reset; push_only with wb_data=8'h05, then with 8'h03 -> ack in c2 of each, sp=2.
REQ-034 ALUSrc=0, RegWrite=1, wb_data=8'h08 in EXEC -> opnd_valid in c3 with opa=03, opb=05; ack in c5; sp=1; next pop reads 08.
REQ-035 sp=1, ALUSrc=0 req -> ack=err=1 in c1; sp stays 1; opnd_valid never asserted.
REQ-036 16 push_only ops -> full=1; 17th -> err=1, sp=16, storage unchanged.
REQ-037 ALUSrc=1, RegWrite=0 at sp=3 -> opb=0, ack in c3, sp=2, no write.
REQ-038 Reset asserted during RD_B -> sp=0, busy=0, ack=0 immediately, no later ack.

Source files
------------

// File: rtl/stack_unit.sv
// Operand stack with single-port storage, sequenced by a small FSM per request.
// Ack latency 1..5 cycles after req depending on pops/push; req ignored while busy.
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic                     ALUSrc,
    input  logic                     RegWrite,
    input  logic                     push_only,
    input  logic [WIDTH-1:0]         wb_data,
    output logic [WIDTH-1:0]         opa,
    output logic [WIDTH-1:0]         opb,
    output logic                     opnd_valid,
    output logic                     ack,
    output logic                     err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        EXEC,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t state, state_nxt;

    logic             need_two;
    logic             push_res;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    sp_lo;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_dat;
    logic [AW:0]      need_req;
    logic [AW:0]      need_cnt;

    assign sp_lo    = sp[AW-1:0];
    // One read port shared by both operand reads: top in RD_A, second in RD_B.
    assign rd_addr  = sp_lo - ((state == RD_B) ? AW'(2) : AW'(1));
    assign rd_dat   = mem[rd_addr];
    assign need_req = ALUSrc ? (AW+1)'(1) : (AW+1)'(2);
    assign need_cnt = need_two ? (AW+1)'(2) : (AW+1)'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (push_only) begin
                        state_nxt = full ? ERR : WRITE;
                    end else if (sp < need_req) begin
                        state_nxt = ERR;
                    end else begin
                        state_nxt = RD_A;
                    end
                end
            end
            RD_A:    state_nxt = need_two ? RD_B : EXEC;
            RD_B:    state_nxt = EXEC;
            EXEC:    state_nxt = push_res ? WRITE : DONE;
            WRITE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp       <= '0;
            opa      <= '0;
            opb      <= '0;
            need_two <= 1'b0;
            push_res <= 1'b0;
            data_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        need_two <= ~ALUSrc;
                        push_res <= RegWrite;
                        if (push_only) begin
                            data_q <= wb_data;
                        end
                    end
                end
                RD_A: begin
                    opa <= rd_dat;
                    if (!need_two) begin
                        opb <= '0;
                    end
                end
                RD_B: opb <= rd_dat;
                EXEC: begin
                    sp     <= sp - need_cnt;
                    data_q <= wb_data;
                end
                WRITE: sp <= sp + (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (state == WRITE) begin
            mem[sp_lo] <= data_q;
        end
    end

    assign opnd_valid = (state == EXEC);
    assign ack        = (state == DONE) || (state == ERR);
    assign err        = (state == ERR);
    assign busy       = (state != IDLE);
    assign empty      = (sp == '0);
    assign full       = (sp == (AW+1)'(DEPTH));

endmodule

// File: tb/tb_stack_unit.sv
// Randomized bench for stack_unit checked against a queue-based stack model.
module tb_stack_unit;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             req;
    logic             ALUSrc;
    logic             RegWrite;
    logic             push_only;
    logic [WIDTH-1:0] wb_data;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             opnd_valid;
    logic             ack;
    logic             err;
    logic             busy;
    logic [4:0]       sp;
    logic             empty;
    logic             full;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] stk[$];
    logic [WIDTH-1:0] m_opa = '0;
    logic [WIDTH-1:0] m_opb = '0;
    logic [WIDTH-1:0] ov_opa;
    logic [WIDTH-1:0] ov_opb;
    int               ov_n;

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .ALUSrc     (ALUSrc),
        .RegWrite   (RegWrite),
        .push_only  (push_only),
        .wb_data    (wb_data),
        .opa        (opa),
        .opb        (opb),
        .opnd_valid (opnd_valid),
        .ack        (ack),
        .err        (err),
        .busy       (busy),
        .sp         (sp),
        .empty      (empty),
        .full       (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One operation: model computes outcome first, then the DUT is driven and observed.
    task automatic do_op(input bit po, input bit as, input bit rw,
                         input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
        int  e_lat;
        bit  e_err;
        int  e_ov;
        int  need;
        int  k;
        int  ack_k;
        int  ov_k;
        bit  err_seen;
        e_err = 1'b0;
        e_ov  = 0;
        if (po) begin
            if (stk.size() == DEPTH) begin
                e_err = 1'b1;
                e_lat = 1;
            end else begin
                stk.push_back(d0);
                e_lat = 2;
            end
        end else begin
            need = as ? 1 : 2;
            if (stk.size() < need) begin
                e_err = 1'b1;
                e_lat = 1;
            end else begin
                m_opa = stk.pop_back();
                if (need == 2) m_opb = stk.pop_back();
                else           m_opb = '0;
                if (rw) stk.push_back(d1);
                e_lat = 2 + need + int'(rw);
                e_ov  = need + 1;
            end
        end

        @(negedge clk);
        req       = 1'b1;
        push_only = po;
        ALUSrc    = as;
        RegWrite  = rw;
        wb_data   = d0;
        k        = 0;
        ack_k    = 0;
        ov_k     = 0;
        ov_n     = 0;
        err_seen = 1'b0;
        while (ack_k == 0 && k < 12) begin
            @(negedge clk);
            k++;
            if (opnd_valid) begin
                ov_n++;
                if (ov_k == 0) begin
                    ov_k   = k;
                    ov_opa = opa;
                    ov_opb = opb;
                end
            end
            if (ack) begin
                ack_k    = k;
                err_seen = err;
                chk("sp", 32'(sp), 32'(stk.size()));
                chk("empty", 32'(empty), 32'(stk.size() == 0));
                chk("full", 32'(full), 32'(stk.size() == DEPTH));
                chk("opa_hold", 32'(opa), 32'(m_opa));
                chk("opb_hold", 32'(opb), 32'(m_opb));
                req = 1'b0;
            end else begin
                // Noise on the control inputs while busy must be ignored.
                req       = 1'($urandom_range(0, 1));
                push_only = 1'($urandom_range(0, 1));
                ALUSrc    = 1'($urandom_range(0, 1));
                RegWrite  = 1'($urandom_range(0, 1));
                if (k == 1) wb_data = d1;
            end
        end
        req = 1'b0;
        chk("ack_lat", 32'(ack_k), 32'(e_lat));
        chk("err", 32'(err_seen), 32'(e_err));
        chk("ov_count", 32'(ov_n), 32'(e_ov != 0));
        if (e_ov != 0) begin
            chk("ov_cycle", 32'(ov_k), 32'(e_ov));
            chk("ov_opa", 32'(ov_opa), 32'(m_opa));
            chk("ov_opb", 32'(ov_opb), 32'(m_opb));
        end
    endtask

    initial begin
        bit seen;
        reset     = 1'b1;
        req       = 1'b0;
        ALUSrc    = 1'b0;
        RegWrite  = 1'b0;
        push_only = 1'b0;
        wb_data   = '0;
        #12;
        chk("rst_sp", 32'(sp), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ov", 32'(opnd_valid), 0);
        chk("rst_opa", 32'(opa), 0);
        chk("rst_opb", 32'(opb), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        @(negedge clk);
        reset = 1'b0;

        // Two pushes then pop-two/push-one.
        do_op(1, 0, 0, 8'h05, 8'h00);
        do_op(1, 0, 0, 8'h03, 8'h00);
        chk("d_sp2", 32'(sp), 2);
        do_op(0, 0, 1, 8'hxx, 8'h08);
        chk("d_opa03", 32'(ov_opa), 32'h03);
        chk("d_opb05", 32'(ov_opb), 32'h05);
        chk("d_sp1", 32'(sp), 1);
        // Underflow reject at sp=1.
        do_op(0, 0, 1, 8'h00, 8'h77);
        chk("d_uf_sp", 32'(sp), 1);
        do_op(0, 1, 1, 8'h00, 8'h08);
        chk("d_pop08", 32'(ov_opa), 32'h08);
        chk("d_pop_opb0", 32'(ov_opb), 0);
        do_op(0, 1, 0, 8'h00, 8'h00);
        chk("d_empty", 32'(empty), 1);

        // Fill to full, then overflow reject, then drain and compare contents.
        for (int i = 0; i < DEPTH; i++) do_op(1, 0, 0, 8'(8'h10 + i), 8'h00);
        chk("d_full", 32'(full), 1);
        do_op(1, 0, 0, 8'hee, 8'h00);
        chk("d_of_sp", 32'(sp), DEPTH);
        do_op(0, 1, 0, 8'h00, 8'h00);
        chk("d_top1f", 32'(ov_opa), 32'h1f);
        chk("d_sp15", 32'(sp), 15);
        for (int i = 0; i < 6; i++) do_op(0, 0, 0, 8'h00, 8'h00);

        // Reset while reading the second operand.
        @(negedge clk);
        req = 1'b1; push_only = 1'b0; ALUSrc = 1'b0; RegWrite = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rb_sp", 32'(sp), 0);
        chk("rb_busy", 32'(busy), 0);
        chk("rb_ack", 32'(ack), 0);
        chk("rb_empty", 32'(empty), 1);
        stk.delete();
        m_opa = '0;
        m_opb = '0;
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack || busy) seen = 1'b1;
        end
        chk("rb_no_ack", 32'(seen), 0);

        // Random operation mix.
        for (int i = 0; i < 300; i++) begin
            bit po;
            if (stk.size() < 2) po = ($urandom_range(0, 3) != 0);
            else                po = ($urandom_range(0, 2) == 0);
            do_op(po, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
